// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neural-network layer controllers.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StGap   = 3'd2,
    StOut   = 3'd3,
    StError = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/watchdog_timer.sv
// Up-counter that flags expiry once LIMIT cycles have been counted since the last clear.
module watchdog_timer #(
  parameter int unsigned LIMIT   = 2,
  parameter int unsigned TIMER_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Combinational so the owner can leave its state on the edge that ends the last cycle.
  assign expire = (r_count == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/network_sequencer.sv
// Sequences a chain of fully-connected layers: accept, enable each layer in turn, capture its
// result, hand the final result downstream; a watchdog aborts a layer that never finishes.
module network_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned LAYER_IDX_W    = ($clog2(NUM_LAYERS) > 0) ? $clog2(NUM_LAYERS) : 1,
  parameter int unsigned TIMER_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  output logic [NUM_LAYERS-1:0]  layerValid,
  input  logic [NUM_LAYERS-1:0]  layerOutValid,
  output logic [NUM_LAYERS-1:0]  capture,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   busy,
  output logic [LAYER_IDX_W-1:0] activeLayer,
  output logic                   timeoutErr,
  input  logic                   clearErr
);

  localparam logic [LAYER_IDX_W-1:0] LastLayer = LAYER_IDX_W'(NUM_LAYERS - 1);

  ctrl_state_e            r_state, w_state_d;
  logic [LAYER_IDX_W-1:0] r_k, w_k_d;
  logic                   w_in_run, w_in_gap, w_done, w_timeout, w_gap_done;
  logic [NUM_LAYERS-1:0]  w_layer_valid_d, w_capture_d;

  assign w_in_run = (r_state == StRun);
  assign w_in_gap = (r_state == StGap);
  assign w_done   = w_in_run && layerOutValid[r_k];

  watchdog_timer #(
    .LIMIT   (TIMEOUT_CYCLES),
    .TIMER_W (TIMER_W)
  ) u_layer_wdt (
    .clk    (clk),
    .reset  (reset),
    .clear  (!w_in_run),
    .enable (w_in_run),
    .expire (w_timeout)
  );

  watchdog_timer #(
    .LIMIT   (GAP_CYCLES),
    .TIMER_W ($clog2(GAP_CYCLES + 1))
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!w_in_gap),
    .enable (w_in_gap),
    .expire (w_gap_done)
  );

  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    case (r_state)
      StIdle: begin
        if (inValid && inReady) begin
          w_state_d = StRun;
          w_k_d     = '0;
        end
      end
      StRun: begin
        // A done in the final watchdog cycle still counts.
        if (w_done) begin
          w_state_d = (r_k == LastLayer) ? StOut : StGap;
        end else if (w_timeout) begin
          w_state_d = StError;
        end
      end
      StGap: begin
        if (w_gap_done) begin
          w_state_d = StRun;
          w_k_d     = r_k + 1'b1;
        end
      end
      StOut: begin
        if (outValid && outReady) begin
          w_state_d = StIdle;
        end
      end
      StError: begin
        if (clearErr) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_layer_valid_d = '0;
    w_capture_d     = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_layer_valid_d[i] = (w_state_d == StRun) && (w_k_d == LAYER_IDX_W'(i));
      w_capture_d[i]     = w_done && (r_k == LAYER_IDX_W'(i));
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_k         <= '0;
      inReady     <= 1'b0;
      layerValid  <= '0;
      capture     <= '0;
      outValid    <= 1'b0;
      busy        <= 1'b0;
      activeLayer <= '0;
      timeoutErr  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_k         <= w_k_d;
      inReady     <= (w_state_d == StIdle);
      layerValid  <= w_layer_valid_d;
      capture     <= w_capture_d;
      // The last capture gets its own cycle before the result is offered.
      outValid    <= (w_state_d == StOut) && (r_state == StOut);
      busy        <= (w_state_d != StIdle);
      activeLayer <= (w_state_d == StRun) ? w_k_d : '0;
      timeoutErr  <= (w_state_d == StError);
    end
  end

endmodule
